// File: rtl/spi_frame_ctrl.sv
// ============================================================================
// spi_frame_ctrl : SPI frame capture, opcode decode, command FIFO, status byte
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_frame_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_RX_DV,
  input  logic [63:0] i_RX_64Bit,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  output logic        o_Cmd_Valid,
  input  logic        i_Cmd_Ready,
  output logic [7:0]  o_Cmd_Addr,
  output logic [47:0] o_Cmd_Data,
  output logic [7:0]  o_Err_Count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_STATUS = 2'd2
  } state_t;

  localparam logic [7:0]  c_OP_WRITE  = 8'h01;
  localparam logic [7:0]  c_OP_FLUSH  = 8'h02;
  localparam logic [7:0]  c_OP_STATUS = 8'h03;
  localparam logic [7:0]  c_OP_CLEAR  = 8'h04;
  localparam logic [AW:0] c_FULL      = (AW+1)'(DEPTH);

  state_t         r_state, w_state_nxt;
  logic [63:0]    r_frame;
  logic [55:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count, w_count_nxt;
  logic           r_ovf, r_err, w_ovf_nxt, w_err_nxt;
  logic [7:0]     r_err_cnt, w_err_cnt_nxt;
  logic [8:0]     w_ecnt_sum;
  logic           r_tx_dv;
  logic [7:0]     r_tx_byte, w_status;
  logic [4:0]     w_cnt_wide;
  logic [55:0]    w_head;
  logic [7:0]     w_op;
  logic           w_is_dec, w_full, w_empty, w_pop, w_pop_eff, w_push, w_flush;
  logic           w_ovf_set, w_clear, w_bad, w_drop;

  assign w_op      = r_frame[63:56];
  assign w_is_dec  = (r_state == S_DECODE);
  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && i_Cmd_Ready;
  assign w_flush   = w_is_dec && (w_op == c_OP_FLUSH);
  assign w_pop_eff = w_pop && !w_flush;
  // Fullness is judged before any same-cycle pop, so a pop never makes room.
  assign w_push    = w_is_dec && (w_op == c_OP_WRITE) && !w_full;
  assign w_ovf_set = w_is_dec && (w_op == c_OP_WRITE) && w_full;
  assign w_clear   = w_is_dec && (w_op == c_OP_CLEAR);
  assign w_drop    = i_RX_DV && (r_state != S_IDLE);

  always_comb begin
    w_bad = 1'b0;
    if (w_is_dec) begin
      case (w_op)
        c_OP_WRITE, c_OP_FLUSH, c_OP_STATUS, c_OP_CLEAR: w_bad = 1'b0;
        default:                                         w_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_RX_DV) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_STATUS;
      S_STATUS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)                 w_count_nxt = '0;
    else if (w_push && !w_pop_eff) w_count_nxt = r_count + (AW+1)'(1);
    else if (!w_push && w_pop_eff) w_count_nxt = r_count - (AW+1)'(1);
  end

  // A drop landing in the CLEAR cycle is counted after the clear.
  assign w_ovf_nxt     = w_clear ? 1'b0 : (r_ovf | w_ovf_set);
  assign w_err_nxt     = (w_clear ? 1'b0 : (r_err | w_bad)) | w_drop;
  assign w_ecnt_sum    = {1'b0, (w_clear ? 8'd0 : r_err_cnt)} + {8'd0, w_bad} + {8'd0, w_drop};
  assign w_err_cnt_nxt = w_ecnt_sum[8] ? 8'hFF : w_ecnt_sum[7:0];

  assign w_cnt_wide = 5'(w_count_nxt);
  assign w_status   = {w_ovf_nxt, w_err_nxt, (w_count_nxt == '0), (w_count_nxt == c_FULL),
                       (w_cnt_wide[4] ? 4'hF : w_cnt_wide[3:0])};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h20;
    end else begin
      r_state   <= w_state_nxt;
      if ((r_state == S_IDLE) && i_RX_DV) r_frame <= i_RX_64Bit;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push)    r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop_eff) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      r_ovf     <= w_ovf_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_tx_dv   <= (r_state == S_STATUS);
      if (r_state == S_STATUS) r_tx_byte <= w_status;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_frame[55:0];
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_Cmd_Valid = !w_empty;
  assign o_Cmd_Addr  = w_empty ? 8'd0  : w_head[55:48];
  assign o_Cmd_Data  = w_empty ? 48'd0 : w_head[47:0];
  assign o_TX_DV     = r_tx_dv;
  assign o_TX_Byte   = r_tx_byte;
  assign o_Err_Count = r_err_cnt;

endmodule

`default_nettype wire

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Command controller behind the 64-bit SPI slave receiver. It captures each received 64-bit frame and decodes its opcode. Write frames are queued in a FIFO and handed to a downstream consumer over a valid/ready handshake. It also keeps a status byte and loads it into the slave's MISO byte register, so the master reads current status on the next transaction.

Parameters:
DEPTH, 8, FIFO depth in frames; power of 2, range 2..16.
AW, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
i_Clk  input  1  FPGA clock, same domain as the slave's o_RX_DV / o_RX_64Bit.
i_Rst_L  input  1  asynchronous reset, active low.
i_RX_DV  input  1  one-cycle pulse: i_RX_64Bit is valid.
i_RX_64Bit  input  64  frame: [63:56] opcode, [55:48] addr, [47:0] payload.
o_TX_DV  output  1  one-cycle pulse: load o_TX_Byte into the slave.
o_TX_Byte  output  8  status byte to the slave.
o_Cmd_Valid  output  1  FIFO head valid.
i_Cmd_Ready  input  1  consumer accepts the head when high with o_Cmd_Valid.
o_Cmd_Addr  output  8  head frame addr.
o_Cmd_Data  output  48  head frame payload.
o_Err_Count  output  8  count of bad-opcode and dropped frames; saturates at 8'hFF.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - FSM = S_IDLE; FIFO empty; sticky flags cleared.
  - o_TX_DV=0, o_TX_Byte=8'h20 (empty bit set), o_Cmd_Valid=0, o_Cmd_Addr=0, o_Cmd_Data=0, o_Err_Count=0.
- FSM states: S_IDLE, S_DECODE, S_STATUS.
  - S_IDLE: on i_RX_DV, register the frame and go to S_DECODE.
  - S_DECODE: execute the opcode (one cycle), go to S_STATUS.
  - S_STATUS: recompute the status byte, drive it on o_TX_Byte, pulse o_TX_DV for that cycle, go to S_IDLE.
  - Latency: o_TX_DV is high exactly 3 cycles after the i_RX_DV cycle. Each frame occupies exactly 3 cycles.
- i_RX_DV seen while not in S_IDLE:
  - Frame is dropped; sticky ERR is set; o_Err_Count increments.
  - The frame in progress completes normally.
- Opcodes, executed in S_DECODE:
  - 8'h01 WRITE: push {addr, payload} to the FIFO. If the FIFO is full, drop the frame and set sticky OVF. A pop in the same cycle does NOT make room.
  - 8'h02 FLUSH: empty the FIFO (wr_ptr=rd_ptr=0). Flush wins over a same-cycle pop, and o_Cmd_Valid is 0 the next cycle.
  - 8'h03 STATUS: no action; status is refreshed in S_STATUS as for every frame.
  - 8'h04 CLEAR: clear sticky OVF, ERR and o_Err_Count. The status byte sent afterwards reflects the cleared state.
  - Any other opcode: set ERR, increment o_Err_Count. An opcode of 8'h00 counts as illegal.
- Status byte: {OVF, ERR, empty, full, count[3:0]}.
  - count = FIFO occupancy, saturating at 4'hF (relevant only when DEPTH=16).
  - Sampled in S_STATUS, after the S_DECODE update and any pops up to and including that cycle.
- FIFO:
  - AW-bit pointers plus an occupancy counter of AW+1 bits; full when count==DEPTH.
  - o_Cmd_Valid = !empty. o_Cmd_Addr and o_Cmd_Data show the head entry (registered RAM read or first-word-fall-through, whichever meets timing) and are stable while o_Cmd_Valid && !i_Cmd_Ready.
  - A pop occurs on o_Cmd_Valid && i_Cmd_Ready, in any FSM state.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged; pointers wrap modulo DEPTH.
  - Pop on empty is ignored.
- o_Err_Count saturates at 8'hFF and does not wrap.
- Reset mid-frame: all state is discarded. No o_TX_DV pulse for the aborted frame.

Test Plan:
- Reset, then idle 10 cycles -> o_TX_Byte=8'h20, o_Cmd_Valid=0, o_TX_DV never high.
- WRITE frame 64'h01_5A_0000_DEAD_BEEF with i_Cmd_Ready=0 -> o_TX_DV pulse 3 cycles after i_RX_DV, o_TX_Byte=8'h01, o_Cmd_Valid=1, o_Cmd_Addr=8'h5A, o_Cmd_Data=48'h0000DEADBEEF. Raise ready for one cycle -> o_Cmd_Valid=0.
- 9 WRITEs with DEPTH=8 and ready=0 -> 8th status = 8'h18, 9th status = 8'h98 (OVF set); FIFO head is still the 1st frame.
- Opcode 8'h7F, then CLEAR -> first status has ERR set (8'h60 when empty), o_Err_Count=1; after CLEAR status = 8'h20, o_Err_Count=0.
- FIFO holds 3 entries; FLUSH with i_Cmd_Ready=1 in the S_DECODE cycle -> status = 8'h20, no further pops.
- Second i_RX_DV one cycle after the first -> second frame dropped, ERR set, o_Err_Count=1, exactly one o_TX_DV pulse.
